// File: rtl/psum_writeback_if.sv
// rtl/psum_writeback_if.sv - controller, OFIFO and psum SRAM signals of the writeback block
interface psum_writeback_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 11
);
  logic                     start;
  logic [addr_bw-1:0]       num_vec;
  logic [addr_bw-1:0]       base_addr;
  logic                     hold;
  logic                     ofifo_valid;
  logic [psum_bw*col-1:0]   ofifo_data;
  logic                     ofifo_rd;
  logic                     mem_cen;
  logic                     mem_wen;
  logic [addr_bw-1:0]       mem_a;
  logic [psum_bw*col-1:0]   mem_d;
  logic                     busy;
  logic                     done;

  modport slave (
    input  start, num_vec, base_addr, hold, ofifo_valid, ofifo_data,
    output ofifo_rd, mem_cen, mem_wen, mem_a, mem_d, busy, done
  );

  modport master (
    output start, num_vec, base_addr, hold, ofifo_valid, ofifo_data,
    input  ofifo_rd, mem_cen, mem_wen, mem_a, mem_d, busy, done
  );
endinterface

// File: rtl/psum_writeback.sv
// rtl/psum_writeback.sv - drains psum rows from the corelet OFIFO into consecutive psum SRAM addresses
module psum_writeback #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  psum_writeback_if.slave      bus
);
  localparam int DW = psum_bw * col;

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

  state_t             state_q, state_d;
  logic [addr_bw-1:0] remaining_q, remaining_d;
  logic [addr_bw-1:0] wr_addr_q, wr_addr_d;
  logic [addr_bw-1:0] mem_a_q, mem_a_d;
  logic [DW-1:0]      mem_d_q, mem_d_d;
  logic               mem_cen_q, mem_cen_d;
  logic               done_q, done_d;
  logic               rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      remaining_q <= '0;
      wr_addr_q   <= '0;
      mem_a_q     <= '0;
      mem_d_q     <= '0;
      mem_cen_q   <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      remaining_q <= remaining_d;
      wr_addr_q   <= wr_addr_d;
      mem_a_q     <= mem_a_d;
      mem_d_q     <= mem_d_d;
      mem_cen_q   <= mem_cen_d;
      done_q      <= done_d;
    end
  end

  // The popped row goes straight into the SRAM port register: one cycle pop-to-write.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    wr_addr_d   = wr_addr_q;
    mem_a_d     = mem_a_q;
    mem_d_d     = mem_d_q;
    mem_cen_d   = 1'b1;
    done_d      = 1'b0;
    rd          = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          remaining_d = bus.num_vec;
          wr_addr_d   = bus.base_addr;
          state_d     = (bus.num_vec != '0) ? DRAIN : FLUSH;
        end
      end
      DRAIN: begin
        rd = bus.ofifo_valid & ~bus.hold & (remaining_q != '0);
        if (rd) begin
          mem_cen_d   = 1'b0;
          mem_a_d     = wr_addr_q;
          mem_d_d     = bus.ofifo_data;
          wr_addr_d   = wr_addr_q + addr_bw'(1);
          remaining_d = remaining_q - addr_bw'(1);
          if (remaining_q == addr_bw'(1)) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ofifo_rd = rd;
  assign bus.mem_cen  = mem_cen_q;
  assign bus.mem_wen  = mem_cen_q;
  assign bus.mem_a    = mem_a_q;
  assign bus.mem_d    = mem_d_q;
  assign bus.busy     = (state_q == DRAIN) || (state_q == FLUSH);
  assign bus.done     = done_q;
endmodule

// File: tb/tb_psum_writeback.sv
// tb/tb_psum_writeback.sv - randomized scoreboard bench for psum_writeback
module tb_psum_writeback;
  localparam int COL = 8;
  localparam int PBW = 16;
  localparam int ABW = 11;
  localparam int DW  = COL * PBW;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  psum_writeback_if #(.col(COL), .psum_bw(PBW), .addr_bw(ABW)) bus ();
  psum_writeback #(.col(COL), .psum_bw(PBW), .addr_bw(ABW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the OFIFO contents, job progress and the expected SRAM writes.
  logic [DW-1:0]  fifo[$];
  logic [ABW-1:0] exp_a[$];
  logic [DW-1:0]  exp_d[$];
  int             m_rem  = 0;
  int             m_cd   = 0;
  int             m_pops = 0;
  bit             m_busy = 0;
  bit             m_done = 0;
  logic [ABW-1:0] m_addr = '0;
  logic [ABW-1:0] last_a = '0;
  logic [DW-1:0]  last_d = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd_row();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic cyc(input bit st, input int nv, input logic [ABW-1:0] ba,
                     input bit hd, input bit gate, input bit rst);
    bit exp_rd;
    bit was_busy;
    @(negedge clk);
    reset            = rst;
    bus.start        = st;
    bus.num_vec      = ABW'(nv);
    bus.base_addr    = ba;
    bus.hold         = hd;
    bus.ofifo_valid  = gate && (fifo.size() > 0);
    bus.ofifo_data   = bus.ofifo_valid ? fifo[0] : rnd_row();
    #1;
    exp_rd = !rst && (m_rem > 0) && bus.ofifo_valid && !hd;
    chk("ofifo_rd", DW'(bus.ofifo_rd), DW'(exp_rd));
    chk("busy", DW'(bus.busy), DW'(m_busy));
    chk("done", DW'(bus.done), DW'(m_done));
    @(posedge clk);
    was_busy = m_busy;
    if (rst) begin
      m_rem = 0; m_cd = 0; m_busy = 0; m_done = 0;
      fifo.delete();
      last_a = '0; last_d = '0;
    end else begin
      m_done = (m_cd == 1);
      if (m_cd > 0) m_cd--;
      if (exp_rd) begin
        exp_a.push_back(m_addr);
        exp_d.push_back(fifo.pop_front());
        m_addr++;
        m_rem--;
        m_pops++;
        if (m_rem == 0) m_cd = 1;
      end
      if (st && !was_busy) begin
        m_rem = nv; m_addr = ba; m_pops = 0;
        if (nv == 0) m_cd = 1;
      end
      m_busy = (m_rem > 0) || (m_cd > 0);
    end
  endtask

  // mode 0: steady; 1: valid toggles; 2: hold for two cycles; 3: random gaps/hold/starts
  task automatic job(input int nv, input logic [ABW-1:0] ba, input int mode, input int abort_after);
    int  k;
    bit  gate, hd, st;
    for (int i = 0; i < nv; i++) fifo.push_back(rnd_row());
    cyc(1'b1, nv, ba, 1'b0, 1'b1, 1'b0);
    k = 0;
    while (m_busy && k < 300) begin
      gate = 1'b1; hd = 1'b0; st = 1'b0;
      case (mode)
        1: gate = (k % 2 == 0);
        2: hd = (k == 2 || k == 3);
        3: begin
          gate = ($urandom_range(0, 3) != 0);
          hd   = ($urandom_range(0, 4) == 0);
          st   = ($urandom_range(0, 5) == 0);
        end
        default: ;
      endcase
      if (abort_after >= 0 && m_pops == abort_after) begin
        cyc(1'b0, 0, '0, 1'b0, 1'b0, 1'b1);
      end else begin
        cyc(st, st ? int'($urandom_range(0, 9)) : 0, ABW'($urandom), hd, gate, 1'b0);
      end
      k++;
    end
    if (k >= 300) chk("job_timeout", 1, 0);
    cyc(1'b0, 0, '0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 0, '0, 1'b0, 1'b1, 1'b0);
    chk("writes_outstanding", DW'(exp_a.size()), 0);
    chk("rows_left", DW'(fifo.size()), 0);
  endtask

  initial begin : monitor
    int a;
    forever begin
      @(negedge clk);
      if (bus.mem_cen === 1'b0) begin
        chk("mem_wen", DW'(bus.mem_wen), 0);
        if (exp_a.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          last_a = exp_a.pop_front();
          last_d = exp_d.pop_front();
          chk("mem_a", DW'(bus.mem_a), DW'(last_a));
          chk("mem_d", bus.mem_d, last_d);
        end
      end else begin
        chk("mem_cen_idle", DW'(bus.mem_cen), 1);
        chk("mem_wen_idle", DW'(bus.mem_wen), 1);
        chk("mem_a_hold", DW'(bus.mem_a), DW'(last_a));
        chk("mem_d_hold", bus.mem_d, last_d);
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.num_vec = '0; bus.base_addr = '0;
    bus.hold = 1'b0; bus.ofifo_valid = 1'b0; bus.ofifo_data = '0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 4, 11'h020, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 0, '0, 1'b0, 1'b0, 1'b0);
    chk("rst_mem_cen", DW'(bus.mem_cen), 1);
    chk("rst_mem_wen", DW'(bus.mem_wen), 1);
    chk("rst_mem_a", DW'(bus.mem_a), 0);
    chk("rst_mem_d", bus.mem_d, 0);

    job(4, 11'h010, 0, -1);
    job(3, 11'h100, 1, -1);
    job(4, 11'h7FE, 0, -1);
    job(6, 11'h200, 2, -1);
    job(0, 11'h300, 0, -1);
    job(5, 11'h400, 0, 2);
    job(1, 11'h401, 0, -1);
    for (int j = 0; j < 15; j++) job($urandom_range(0, 8), ABW'($urandom), 3, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
